// File: rtl/acc9_pkg.sv
// Shared widths and FSM state type for the 9-bit delta integrator.
package acc9_pkg;

    localparam int ACC_W    = 9;
    localparam int SUM_W    = 11;
    localparam int SATCNT_W = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/acc9_clamp.sv
// Combinational clamp of an 11-bit signed sum into the unsigned range [min_val, max_val],
// with flags telling which bound was hit.
module acc9_clamp
    import acc9_pkg::*;
(
    input  logic signed [SUM_W-1:0] sum,
    input  logic        [ACC_W-1:0] min_val,
    input  logic        [ACC_W-1:0] max_val,
    output logic        [ACC_W-1:0] result,
    output logic                    hi,
    output logic                    lo
);

    logic signed [SUM_W-1:0] min_s;
    logic signed [SUM_W-1:0] max_s;

    assign min_s = $signed({2'b00, min_val});
    assign max_s = $signed({2'b00, max_val});

    always_comb begin
        result = sum[ACC_W-1:0];
        hi     = 1'b0;
        lo     = 1'b0;
        if (sum > max_s) begin
            result = max_val;
            hi     = 1'b1;
        end else if (sum < min_s) begin
            result = min_val;
            lo     = 1'b1;
        end
    end

endmodule

// File: rtl/acc9_integrator.sv
// Integrates signed 9-bit deltas into a clamped unsigned 9-bit command with valid/ready on both sides.
// Define ACC9_WRAP_EN for modulo-512 delta updates (sat_cnt then counts wrap events).
module acc9_integrator
    import acc9_pkg::*;
#(
    parameter logic [ACC_W-1:0] MIN_VAL  = 9'd0,
    parameter logic [ACC_W-1:0] MAX_VAL  = 9'd511,
    parameter logic [ACC_W-1:0] INIT_VAL = 9'd0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic signed [ACC_W-1:0]    delta,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       load,
    input  logic        [ACC_W-1:0]    load_val,
    output logic        [ACC_W-1:0]    acc_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       sat_hi,
    output logic                       sat_lo,
    output logic        [SATCNT_W-1:0] sat_cnt
);

    state_e                 state_q, state_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic                   sat_hi_q, sat_hi_d;
    logic                   sat_lo_q, sat_lo_d;
    logic [SATCNT_W-1:0]    sat_cnt_q, sat_cnt_d;

    logic                   accept;
    logic                   produce;
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] load_sum;
    logic [ACC_W-1:0]       ld_res;
    logic                   ld_hi, ld_lo;

    function automatic logic [SATCNT_W-1:0] sat_inc(input logic [SATCNT_W-1:0] c);
        return (c == {SATCNT_W{1'b1}}) ? c : c + SATCNT_W'(1);
    endfunction

    assign in_ready = (state_q == EMPTY) | out_ready;
    assign accept   = in_valid & in_ready;

    assign sum      = $signed({2'b00, acc_q}) + $signed({{2{delta[ACC_W-1]}}, delta});
    assign load_sum = $signed({2'b00, load_val});

    acc9_clamp u_load_clamp (
        .sum     (load_sum),
        .min_val (MIN_VAL),
        .max_val (MAX_VAL),
        .result  (ld_res),
        .hi      (ld_hi),
        .lo      (ld_lo)
    );

`ifdef ACC9_WRAP_EN
    logic wrapped;
    assign wrapped = (sum[SUM_W-1:ACC_W] != 2'b00);
`else
    logic [ACC_W-1:0] dlt_res;
    logic             dlt_hi, dlt_lo;

    acc9_clamp u_delta_clamp (
        .sum     (sum),
        .min_val (MIN_VAL),
        .max_val (MAX_VAL),
        .result  (dlt_res),
        .hi      (dlt_hi),
        .lo      (dlt_lo)
    );
`endif

    // A load wins over a same-cycle delta; the delta is still handshaken but dropped.
    always_comb begin
        acc_d     = acc_q;
        sat_hi_d  = sat_hi_q;
        sat_lo_d  = sat_lo_q;
        sat_cnt_d = sat_cnt_q;
        produce   = 1'b0;
        if (load) begin
            produce  = 1'b1;
            acc_d    = ld_res;
            sat_hi_d = ld_hi;
            sat_lo_d = ld_lo;
        end else if (accept) begin
            produce = 1'b1;
`ifdef ACC9_WRAP_EN
            acc_d    = sum[ACC_W-1:0];
            sat_hi_d = 1'b0;
            sat_lo_d = 1'b0;
            if (wrapped) begin
                sat_cnt_d = sat_inc(sat_cnt_q);
            end
`else
            acc_d    = dlt_res;
            sat_hi_d = dlt_hi;
            sat_lo_d = dlt_lo;
            if (dlt_hi | dlt_lo) begin
                sat_cnt_d = sat_inc(sat_cnt_q);
            end
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (produce) state_d = FULL;
            FULL:    if (out_ready && !produce) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Output register stage: result visible one edge after accept or load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            acc_q     <= INIT_VAL;
            sat_hi_q  <= 1'b0;
            sat_lo_q  <= 1'b0;
            sat_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            sat_hi_q  <= sat_hi_d;
            sat_lo_q  <= sat_lo_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign acc_out   = acc_q;
    assign out_valid = (state_q == FULL);
    assign sat_hi    = sat_hi_q;
    assign sat_lo    = sat_lo_q;
    assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_acc9_integrator.sv
// Scoreboard bench for acc9_integrator: stimulus pushes expected results, monitors pop on each consumed output.
module tb_acc9_integrator;

`ifdef ACC9_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    typedef struct packed {
        logic [8:0] acc;
        logic       hi;
        logic       lo;
        logic [7:0] cnt;
    } exp_t;

    logic              clk;
    logic              rst_n;
    // instance A: MIN 0, MAX 511, INIT 100
    logic signed [8:0] delta;
    logic              in_valid, in_ready, load, out_valid, out_ready, sat_hi, sat_lo;
    logic [8:0]        load_val, acc_out;
    logic [7:0]        sat_cnt;
    // instance B: MIN 50, MAX 200, INIT 60
    logic signed [8:0] delta_b;
    logic              in_valid_b, in_ready_b, load_b, out_valid_b, out_ready_b, sat_hi_b, sat_lo_b;
    logic [8:0]        load_val_b, acc_out_b;
    logic [7:0]        sat_cnt_b;

    int   checks   = 0;
    int   failures = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    acc9_integrator #(.MIN_VAL(9'd0), .MAX_VAL(9'd511), .INIT_VAL(9'd100)) u_dut (
        .clk(clk), .rst_n(rst_n), .delta(delta), .in_valid(in_valid), .in_ready(in_ready),
        .load(load), .load_val(load_val), .acc_out(acc_out), .out_valid(out_valid),
        .out_ready(out_ready), .sat_hi(sat_hi), .sat_lo(sat_lo), .sat_cnt(sat_cnt)
    );

    acc9_integrator #(.MIN_VAL(9'd50), .MAX_VAL(9'd200), .INIT_VAL(9'd60)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .delta(delta_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .load(load_b), .load_val(load_val_b), .acc_out(acc_out_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .sat_hi(sat_hi_b), .sat_lo(sat_lo_b), .sat_cnt(sat_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (q_a.size() == 0) begin
                failures++;
                $display("FAIL a_unexpected_output got acc=%0d required no output", acc_out);
            end else begin
                e = q_a.pop_front();
                if ({acc_out, sat_hi, sat_lo, sat_cnt} !== e) begin
                    failures++;
                    $display("FAIL a_result got acc=%0d hi=%0b lo=%0b cnt=%0d required acc=%0d hi=%0b lo=%0b cnt=%0d",
                             acc_out, sat_hi, sat_lo, sat_cnt, e.acc, e.hi, e.lo, e.cnt);
                end
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (rst_n && out_valid_b && out_ready_b) begin
            checks++;
            if (q_b.size() == 0) begin
                failures++;
                $display("FAIL b_unexpected_output got acc=%0d required no output", acc_out_b);
            end else begin
                e = q_b.pop_front();
                if ({acc_out_b, sat_hi_b, sat_lo_b, sat_cnt_b} !== e) begin
                    failures++;
                    $display("FAIL b_result got acc=%0d hi=%0b lo=%0b cnt=%0d required acc=%0d hi=%0b lo=%0b cnt=%0d",
                             acc_out_b, sat_hi_b, sat_lo_b, sat_cnt_b, e.acc, e.hi, e.lo, e.cnt);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s got %0d required %0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input int acc, input bit hi, input bit lo, input int cnt);
        exp_t e;
        e.acc = 9'(acc);
        e.hi  = hi;
        e.lo  = lo;
        e.cnt = 8'(cnt);
        return e;
    endfunction

    task automatic send_a(input int d, input int acc, input bit hi, input bit lo, input int cnt);
        in_valid = 1'b1;
        delta    = 9'(d);
        q_a.push_back(mk(acc, hi, lo, cnt));
        step();
        in_valid = 1'b0;
        chk("a_out_valid_after_accept", int'(out_valid), 1);
    endtask

    task automatic load_a(input int v, input int acc, input bit hi, input bit lo, input int cnt);
        load     = 1'b1;
        load_val = 9'(v);
        q_a.push_back(mk(acc, hi, lo, cnt));
        step();
        load = 1'b0;
    endtask

    task automatic send_b(input int d, input int acc, input bit hi, input bit lo, input int cnt);
        in_valid_b = 1'b1;
        delta_b    = 9'(d);
        q_b.push_back(mk(acc, hi, lo, cnt));
        step();
        in_valid_b = 1'b0;
    endtask

    task automatic load_bt(input int v, input int acc, input bit hi, input bit lo, input int cnt);
        load_b     = 1'b1;
        load_val_b = 9'(v);
        q_b.push_back(mk(acc, hi, lo, cnt));
        step();
        load_b = 1'b0;
    endtask

    // Reference update for instance A (bounds 0..511), used for the long saturation run.
    function automatic void model_a(input int acc, input int d, output int nacc,
                                    output bit hi, output bit lo, output bit ev);
        int s;
        s = acc + d;
        hi = 1'b0;
        lo = 1'b0;
        if (WRAP) begin
            nacc = s & 511;
            ev   = (s < 0) || (s > 511);
        end else if (s > 511) begin
            nacc = 511; hi = 1'b1; ev = 1'b1;
        end else if (s < 0) begin
            nacc = 0; lo = 1'b1; ev = 1'b1;
        end else begin
            nacc = s; ev = 1'b0;
        end
    endfunction

    initial begin
        int  cnt;
        int  acc_m;
        int  nacc;
        bit  mh, ml, mev;
        int  stall_val;

        rst_n = 1'b0; delta = '0; in_valid = 1'b0; load = 1'b0; load_val = '0; out_ready = 1'b0;
        delta_b = '0; in_valid_b = 1'b0; load_b = 1'b0; load_val_b = '0; out_ready_b = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("reset_acc", int'(acc_out), 100);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_sat_flags", int'({sat_hi, sat_lo}), 0);
        chk("reset_sat_cnt", int'(sat_cnt), 0);
        chk("empty_in_ready_without_out_ready", int'(in_ready), 1);
        chk("reset_acc_b", int'(acc_out_b), 60);

        // Back-to-back deltas from INIT_VAL
        out_ready = 1'b1;
        send_a(20, 120, 0, 0, 0);
        send_a(-50, 70, 0, 0, 0);
        send_a(5, 75, 0, 0, 0);
        step();
        chk("drain_out_valid", int'(out_valid), 0);

        // Upper clamp then recovery
        load_a(500, 500, 0, 0, 0);
        send_a(30, WRAP ? 18 : 511, WRAP ? 1'b0 : 1'b1, 0, 1);
        send_a(-256, WRAP ? 274 : 255, 0, 0, WRAP ? 2 : 1);

        // Lower clamp
        load_a(10, 10, 0, 0, WRAP ? 2 : 1);
        send_a(-20, WRAP ? 502 : 0, 0, WRAP ? 1'b0 : 1'b1, WRAP ? 3 : 2);
        cnt       = WRAP ? 3 : 2;
        stall_val = WRAP ? 502 : 0;

        // Downstream stall with a delta waiting
        out_ready = 1'b0;
        in_valid  = 1'b1;
        delta     = 9'sd7;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_in_ready", int'(in_ready), 0);
            chk("stall_acc_stable", int'(acc_out), stall_val);
            step();
        end
        out_ready = 1'b1;
        q_a.push_back(mk(stall_val + 7, 0, 0, cnt));
        #1;
        chk("release_in_ready", int'(in_ready), 1);
        step();
        in_valid = 1'b0;
        chk("release_acc_next_edge", int'(acc_out), stall_val + 7);

        // Load with simultaneous delta: delta dropped, counter untouched
        in_valid = 1'b1;
        delta    = 9'sd7;
        load_a(300, 300, 0, 0, cnt);
        in_valid = 1'b0;
        step();

        // Long run of clamping deltas: counter must stop at 255
        load_a(511, 511, 0, 0, cnt);
        acc_m = 511;
        for (int i = 0; i < 260; i++) begin
            model_a(acc_m, 200, nacc, mh, ml, mev);
            if (mev && cnt < 255) cnt++;
            acc_m = nacc;
            send_a(200, nacc, mh, ml, cnt);
        end
        out_ready = 1'b0;
        #1;
        chk("sat_cnt_saturated", int'(sat_cnt), WRAP ? cnt : 255);

        // Reset while a result is pending downstream
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        q_a.delete();
        chk("midstall_reset_out_valid", int'(out_valid), 0);
        chk("midstall_reset_acc", int'(acc_out), 100);
        chk("midstall_reset_sat_cnt", int'(sat_cnt), 0);
        chk("midstall_reset_flags", int'({sat_hi, sat_lo}), 0);
        out_ready = 1'b1;
        send_a(1, 101, 0, 0, 0);
        send_a(0, 101, 0, 0, 0);
        step();

        // Instance B: narrower bounds exercise load clamping on both sides
        load_bt(300, 200, 1, 0, 0);
        load_bt(10, 50, 0, 1, 0);
        send_b(100, 150, 0, 0, 0);
        send_b(100, WRAP ? 250 : 200, WRAP ? 1'b0 : 1'b1, 0, WRAP ? 0 : 1);
        send_b(-120, WRAP ? 130 : 80, 0, 0, WRAP ? 0 : 1);
        send_b(-50, WRAP ? 80 : 50, 0, WRAP ? 1'b0 : 1'b1, WRAP ? 0 : 2);
        step();
        step();

        chk("a_queue_drained", q_a.size(), 0);
        chk("b_queue_drained", q_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
